// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream serialiser: one holding register plus slice counter, no bubble between words.
// Optional STREAM_DOWNSIZER_PARTIAL_EN adds i_nslices to emit fewer than DATA_WIDTH/OUT_WIDTH slices per word.
module stream_downsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0,
  localparam int R    = DATA_WIDTH / OUT_WIDTH,
  localparam int CNTW = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid_s,
  output logic                  o_ready_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_valid_m,
  input  logic                  i_ready_m,
  output logic [OUT_WIDTH-1:0]  o_dataout,
  output logic                  o_last,
  output logic                  o_busy
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
  ,
  input  logic [CNTW:0]         i_nslices
`endif
);

  if ((DATA_WIDTH % OUT_WIDTH != 0) || (R < 2)) begin : g_bad_params
    $fatal(1, "stream_downsizer: DATA_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [CNTW-1:0]       idx_q;
  logic [CNTW-1:0]       last_idx;
  logic [CNTW-1:0]       pos;
  logic                  rdy_en_q;
  logic                  full_q;
  logic                  xfer_in;
  logic                  xfer_out;

`ifdef STREAM_DOWNSIZER_PARTIAL_EN
  logic [CNTW:0] nsl_q;
  logic [CNTW:0] nsl_in;

  // Out-of-range counts (0 or > R) collapse to a full word before storage.
  always_comb begin
    nsl_in = i_nslices;
    if ((i_nslices == '0) || (i_nslices > (CNTW+1)'(R)))
      nsl_in = (CNTW+1)'(R);
  end

  assign last_idx = CNTW'(nsl_q - (CNTW+1)'(1));
`else
  assign last_idx = CNTW'(R - 1);
`endif

  assign full_q    = (state_q == SEND);
  assign o_valid_m = full_q;
  assign o_busy    = full_q;
  assign o_last    = full_q && (idx_q == last_idx);
  assign xfer_out  = o_valid_m && i_ready_m;
  // rdy_en_q keeps ready low through reset and the release edge.
  assign o_ready_s = rdy_en_q && (!full_q || (xfer_out && o_last));
  assign xfer_in   = i_valid_s && o_ready_s;

  always_comb begin
    pos = idx_q;
    if (MSB_FIRST != 0)
      pos = CNTW'(R - 1) - idx_q;
  end

  assign o_dataout = buf_q[int'(pos)*OUT_WIDTH +: OUT_WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= EMPTY;
      buf_q    <= '0;
      idx_q    <= '0;
      rdy_en_q <= 1'b0;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      nsl_q    <= (CNTW+1)'(R);
`endif
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            buf_q   <= i_datain;
            idx_q   <= '0;
            state_q <= SEND;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
            nsl_q   <= nsl_in;
`endif
          end
        end
        SEND: begin
          if (xfer_out) begin
            if (!o_last) begin
              idx_q <= idx_q + 1'b1;
            end else if (xfer_in) begin
              buf_q <= i_datain;
              idx_q <= '0;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
              nsl_q <= nsl_in;
`endif
            end else begin
              idx_q   <= '0;
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Scoreboard bench for stream_downsizer: LSB-first and MSB-first instances share one input stream.
module tb_stream_downsizer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid_s;
  logic [31:0] i_datain;
  logic        i_ready_m;
  logic        ra, va, la, ba;
  logic        rb, vb, lb, bb;
  logic [7:0]  da, db;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
  logic [2:0]  ns_drv = 3'd0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          rdy_en   = 1'b0;

  always #5 i_clk = ~i_clk;

  stream_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_s(i_valid_s), .o_ready_s(ra),
    .i_datain(i_datain), .o_valid_m(va), .i_ready_m(i_ready_m),
    .o_dataout(da), .o_last(la), .o_busy(ba)
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
    , .i_nslices(ns_drv)
`endif
  );

  stream_downsizer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid_s(i_valid_s), .o_ready_s(rb),
    .i_datain(i_datain), .o_valid_m(vb), .i_ready_m(i_ready_m),
    .o_dataout(db), .o_last(lb), .o_busy(bb)
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
    , .i_nslices(ns_drv)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset();
    check("rst_valid", {31'd0, va}, 0);
    check("rst_ready", {31'd0, ra}, 0);
    check("rst_last",  {31'd0, la}, 0);
    check("rst_busy",  {31'd0, ba}, 0);
    check("rst_data",  {24'd0, da}, 0);
    check("rst_valid_msb", {31'd0, vb}, 0);
    check("rst_data_msb",  {24'd0, db}, 0);
  endtask

  // One cycle: inputs already driven after a falling edge; sample, score, then advance.
  task automatic step(output bit acc);
    exp_t        e;
    logic [31:0] w;
    int          n;
    bit          exp_rdy;
    #1;
    exp_rdy = rdy_en && ((qa.size() == 0) || (i_ready_m && qa[0].l));
    check("valid", {31'd0, va}, (qa.size() != 0) ? 1 : 0);
    check("ready", {31'd0, ra}, {31'd0, exp_rdy});
    check("ready_msb", {31'd0, rb}, {31'd0, exp_rdy});
    check("busy", {31'd0, ba}, {31'd0, va});
    if (va && i_ready_m) begin
      if (qa.size() == 0) check("lsb_extra_slice", {24'd0, da}, 0);
      else begin
        e = qa.pop_front();
        check("lsb_data", {24'd0, da}, {24'd0, e.d});
        check("lsb_last", {31'd0, la}, {31'd0, e.l});
      end
    end
    if (vb && i_ready_m) begin
      if (qb.size() == 0) check("msb_extra_slice", {24'd0, db}, 0);
      else begin
        e = qb.pop_front();
        check("msb_data", {24'd0, db}, {24'd0, e.d});
        check("msb_last", {31'd0, lb}, {31'd0, e.l});
      end
    end
    acc = i_valid_s && ra;
    if (acc) begin
      w = i_datain;
      n = 4;
`ifdef STREAM_DOWNSIZER_PARTIAL_EN
      if (ns_drv != 0 && ns_drv <= 4) n = int'(ns_drv);
`endif
      for (int k = 0; k < n; k++) begin
        qa.push_back({w[k*8 +: 8], k == n - 1});
        qb.push_back({w[(3-k)*8 +: 8], k == n - 1});
      end
    end
    @(posedge i_clk);
    if (!i_rst) rdy_en = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc = 1'b0;
    i_valid_s = 1'b1;
    i_datain  = w;
    for (int c = 0; c < 20 && !acc; c++) step(acc);
    if (!acc) check("accept_timeout", 0, 1);
    i_valid_s = 1'b0;
    i_datain  = $urandom;
  endtask

  task automatic drain(input int max);
    bit acc;
    int c = 0;
    while ((qa.size() != 0 || qb.size() != 0) && c < max) begin
      step(acc);
      c++;
    end
    check("drain_timeout", qa.size(), 0);
    step(acc);
  endtask

  initial begin
    bit acc;
    i_rst     = 1'b1;
    i_valid_s = 1'b0;
    i_datain  = '0;
    i_ready_m = 1'b1;
    #12;
    check_idle_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step(acc);

    // Single word, plus MSB-first ordering on the second instance.
    send_word(32'hA1B2C3D4);
    drain(10);

    // Back-to-back words: no bubble between them.
    send_word(32'h11223344);
    send_word(32'h55667788);
    drain(12);

    // Backpressure on the third slice.
    send_word(32'hDEADBEEF);
    while (qa.size() > 2) step(acc);
    i_ready_m = 1'b0;
    repeat (3) begin
      check("bp_hold_data", {24'd0, da}, 32'hAD);
      check("bp_hold_last", {31'd0, la}, 0);
      step(acc);
    end
    i_ready_m = 1'b1;
    drain(10);

    // Asynchronous reset mid-word, then a fresh word.
    send_word(32'hCAFEF00D);
    step(acc);
    #2;
    i_rst = 1'b1;
    #1;
    check_idle_reset();
    qa.delete();
    qb.delete();
    rdy_en = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    step(acc);
    step(acc);
    send_word(32'h01020304);
    drain(10);

`ifdef STREAM_DOWNSIZER_PARTIAL_EN
    ns_drv = 3'd3;
    send_word(32'h00AABBCC);
    ns_drv = 3'd0;
    send_word(32'h99887766);
    drain(12);
`endif

    check("final_queue_empty", qa.size() + qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
